// File: rtl/alu_ctrl_pkg.sv
// Shared types and widths for the ALU sequencer/arbiter.
package alu_ctrl_pkg;

  localparam int unsigned ALU_OP_W  = 3;
  localparam int unsigned ALU_IN_W  = 4;
  localparam int unsigned ALU_OUT_W = 8;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_OR   = 3'b000,
    OP_NAND = 3'b001,
    OP_XOR  = 3'b010,
    OP_MUL  = 3'b011,
    OP_ADD  = 3'b100,
    OP_INC  = 3'b101,
    OP_SUB  = 3'b110,
    OP_SHR  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } ctrl_state_e;

endpackage

// File: rtl/alu_arbiter_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the requester after ptr has top priority.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  // Scan ptr+1, ptr+2, ... (mod NUM_REQ); first active request wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    logic            found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Sequencer/arbiter in front of a combinational 4-bit ALU: grants one
// requester at a time, drives the ALU from registers and returns the result.
module alu_arbiter_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ALU_OP_W-1:0]   req_op,
  input  logic [NUM_REQ*ALU_IN_W-1:0]   req_a,
  input  logic [NUM_REQ*ALU_IN_W-1:0]   req_b,
  output logic [ALU_OP_W-1:0]           alu_sel,
  output logic [ALU_IN_W-1:0]           alu_a,
  output logic [ALU_IN_W-1:0]           alu_b,
  input  logic [ALU_OUT_W-1:0]          alu_y,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ALU_OUT_W-1:0]          rsp_data,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          busy,
  output logic [CNT_W-1:0]              op_count
);

  ctrl_state_e         state;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic                accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Offer the grant only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !reset) req_ready = grant;
  end

  assign accept = |(req_valid & req_ready);

  // Main sequencer: operand capture, result capture, response handshake, counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      alu_sel   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_sel <= req_op[32'(grant_id)*ALU_OP_W +: ALU_OP_W];
            alu_a   <= req_a[32'(grant_id)*ALU_IN_W +: ALU_IN_W];
            alu_b   <= req_b[32'(grant_id)*ALU_IN_W +: ALU_IN_W];
            rsp_id  <= grant_id;
            rr_ptr  <= grant_id;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_y;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            op_count  <= op_count + 1'b1;
            alu_sel   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Randomized and directed bench for alu_arbiter_ctrl with a behavioural ALU.
module tb_alu_arbiter_ctrl;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ID_W    = 1;
  localparam int unsigned CNT_W   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [NUM_REQ-1:0]     req_valid, req_ready;
  logic [NUM_REQ*3-1:0]   req_op;
  logic [NUM_REQ*4-1:0]   req_a, req_b;
  logic [2:0]             alu_sel;
  logic [3:0]             alu_a, alu_b;
  logic [7:0]             alu_y;
  logic                   rsp_valid, rsp_ready;
  logic [7:0]             rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   busy;
  logic [CNT_W-1:0]       op_count;

  logic [2:0] cmd_op [NUM_REQ];
  logic [3:0] cmd_a  [NUM_REQ];
  logic [3:0] cmd_b  [NUM_REQ];

  int n_checks = 0;
  int n_errors = 0;

  // model: age 0 free, 1 op computing, 2 response presented, -1 unknown
  int m_age = -1;
  int m_last, m_count, m_id;
  logic [2:0] m_op;
  logic [3:0] m_a, m_b;

  // snapshots of the cycle just evaluated
  logic [NUM_REQ-1:0] s_ready;
  logic s_rsp_valid, s_busy;
  logic [7:0] s_rsp_data;
  logic [ID_W-1:0] s_rsp_id;
  logic [CNT_W-1:0] s_count;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] ea, eb;
    logic [3:0] d;
    ea = {4'b0, a};
    eb = {4'b0, b};
    d  = a - b;
    case (op)
      3'd0: return {4'b0, a | b};
      3'd1: return {4'b0, ~(a & b)};
      3'd2: return {4'b0, a ^ b};
      3'd3: return ea * eb;
      3'd4: return ea + eb;
      3'd5: return ea + 8'd1;
      3'd6: return {4'b0, d};
      default: return {4'b0, a >> 1};
    endcase
  endfunction

  assign alu_y = alu_f(alu_sel, alu_a, alu_b);

  always_comb begin
    req_op = '0;
    req_a  = '0;
    req_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_op[i*3 +: 3] = cmd_op[i];
      req_a[i*4 +: 4]  = cmd_a[i];
      req_b[i*4 +: 4]  = cmd_b[i];
    end
  end

  alu_arbiter_ctrl #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_sel   (alu_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Evaluate the current cycle against the model, then advance one clock.
  task automatic cycle();
    logic [NUM_REQ-1:0] exp_ready;
    int g;
    #1;
    s_ready     = req_ready;
    s_rsp_valid = rsp_valid;
    s_rsp_data  = rsp_data;
    s_rsp_id    = rsp_id;
    s_count     = op_count;
    s_busy      = busy;
    exp_ready   = '0;
    g           = -1;
    if (m_age == 0 && !reset) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (m_last + k) % NUM_REQ;
        if (g < 0 && req_valid[c]) g = c;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    if (m_age >= 0) begin
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("busy", 32'(busy), 32'(m_age != 0));
      check("rsp_valid", 32'(rsp_valid), 32'(m_age == 2));
      check("op_count", 32'(op_count), 32'(m_count));
      check("alu_sel", 32'(alu_sel), (m_age == 0) ? 32'd0 : 32'(m_op));
      check("alu_a", 32'(alu_a), (m_age == 0) ? 32'd0 : 32'(m_a));
      check("alu_b", 32'(alu_b), (m_age == 0) ? 32'd0 : 32'(m_b));
      if (m_age == 2) begin
        check("rsp_data", 32'(rsp_data), 32'(alu_f(m_op, m_a, m_b)));
        check("rsp_id", 32'(rsp_id), 32'(m_id));
      end
    end
    if (reset) begin
      m_age   = 0;
      m_last  = NUM_REQ - 1;
      m_count = 0;
    end else begin
      case (m_age)
        0: if (g >= 0) begin
             m_age  = 1;
             m_last = g;
             m_id   = g;
             m_op   = cmd_op[g];
             m_a    = cmd_a[g];
             m_b    = cmd_b[g];
           end
        1: m_age = 2;
        2: if (rsp_ready) begin
             m_age   = 0;
             m_count = (m_count + 1) % (1 << CNT_W);
           end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    cmd_op[id] = op;
    cmd_a[id]  = a;
    cmd_b[id]  = b;
    req_valid  = req_valid | (NUM_REQ'(1) << id);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  // Single directed op with fixed spec result; checks grant and N+2 latency.
  task automatic do_op(input string tag, input int id, input logic [2:0] op,
                       input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp_data);
    set_cmd(id, op, a, b);
    rsp_ready = 1'b1;
    cycle();
    check({tag, "_ready"}, 32'(s_ready), 32'(1 << id));
    req_valid = '0;
    cycle();
    check({tag, "_early"}, 32'(s_rsp_valid), 32'd0);
    cycle();
    check({tag, "_valid"}, 32'(s_rsp_valid), 32'd1);
    check({tag, "_data"}, 32'(s_rsp_data), 32'(exp_data));
    check({tag, "_id"}, 32'(s_rsp_id), 32'(id));
    cycle();
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cmd_op[i] = '0;
      cmd_a[i]  = '0;
      cmd_b[i]  = '0;
    end
    @(posedge clk);
    #1;
    do_reset();
    cycle();
    check("rst_busy", 32'(s_busy), 32'd0);
    check("rst_rsp_valid", 32'(s_rsp_valid), 32'd0);
    check("rst_count", 32'(s_count), 32'd0);

    do_op("t1_add", 0, 3'b100, 4'b0110, 4'b1011, 8'h11);
    do_op("t2_mul", 1, 3'b011, 4'b1011, 4'b0111, 8'h4D);
    do_op("t2_sub", 1, 3'b110, 4'b0110, 4'b1011, 8'h0B);

    // both requesters continuously valid: strict alternation from req 0
    do_reset();
    set_cmd(0, 3'b010, 4'b1100, 4'b0101);
    set_cmd(1, 3'b000, 4'b0011, 4'b1000);
    rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      cycle();
      if (s_rsp_valid) begin
        check("t3_id", 32'(s_rsp_id), 32'(n % 2));
        n++;
      end
    end
    req_valid = '0;
    check("t3_n", 32'(n), 32'd6);
    cycle();
    check("t3_count", 32'(s_count), 32'd6);

    // response back-pressure for 5 cycles
    set_cmd(0, 3'b010, 4'b1010, 4'b0110);
    rsp_ready = 1'b0;
    cycle();
    req_valid = '1;
    cycle();
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("t4_valid", 32'(s_rsp_valid), 32'd1);
      check("t4_data", 32'(s_rsp_data), 32'h0C);
      check("t4_id", 32'(s_rsp_id), 32'd0);
      check("t4_ready", 32'(s_ready), 32'd0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    cycle();
    cycle();

    // reset while the op is in EXEC
    set_cmd(1, 3'b100, 4'b0001, 4'b0001);
    cycle();
    req_valid = '0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    check("t5_rsp_valid", 32'(s_rsp_valid), 32'd0);
    check("t5_busy", 32'(s_busy), 32'd0);
    check("t5_count", 32'(s_count), 32'd0);
    set_cmd(0, 3'b101, 4'b1111, 4'b0000);
    set_cmd(1, 3'b111, 4'b1001, 4'b0000);
    cycle();
    check("t5_grant", 32'(s_ready), 32'd1);
    req_valid = '0;
    cycle();
    cycle();
    cycle();

    // counter wrap with CNT_W=4
    do_reset();
    n = 0;
    set_cmd(0, 3'b011, 4'b1111, 4'b1111);
    set_cmd(1, 3'b001, 4'b1010, 4'b0110);
    rsp_ready = 1'b1;
    for (int c = 0; c < 80 && n < 17; c++) begin
      cycle();
      if (s_rsp_valid) n++;
    end
    req_valid = '0;
    check("t7_n", 32'(n), 32'd17);
    cycle();
    check("t7_wrap", 32'(s_count), 32'd1);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && s_ready[i]) req_valid[i] = 1'b0;
        else if (req_valid[i] && $urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_cmd(i, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      rsp_ready = 1'($urandom_range(0, 1));
      reset     = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
